// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: states, opcodes, ALU function codes.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    StRst, StF0, StF1, StF2, StF3, StDec,
    StR0, StR1, StR2, StR3,
    StL0, StL1, StL2, StL3,
    StS0, StS1, StS2, StS3, StS4,
    StB0, StB1, StB2,
    StHlt
  } state_e;

  localparam logic [6:0] OpcRFirst = 7'h01;
  localparam logic [6:0] OpcRLast  = 7'h06;
  localparam logic [6:0] OpcLd     = 7'h10;
  localparam logic [6:0] OpcSt     = 7'h11;
  localparam logic [6:0] OpcBz     = 7'h20;
  localparam logic [6:0] OpcBc     = 7'h21;
  localparam logic [6:0] OpcBs     = 7'h22;
  localparam logic [6:0] OpcBv     = 7'h23;
  localparam logic [6:0] OpcJmp    = 7'h24;
  localparam logic [6:0] OpcHlt    = 7'h7F;

  localparam logic [2:0] FselAdd   = 3'd0;
  localparam logic [2:0] FselSub   = 3'd1;
  localparam logic [2:0] FselAnd   = 3'd2;
  localparam logic [2:0] FselOr    = 3'd3;
  localparam logic [2:0] FselXor   = 3'd4;
  localparam logic [2:0] FselNot   = 3'd5;
  localparam logic [2:0] FselPassX = 3'd7;

  // Bit positions inside the latched {C, V, S, Z} flag word.
  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagS = 1;
  localparam int unsigned FlagZ = 0;

endpackage

// File: rtl/cpu_control_unit_branch.sv
// Branch-condition evaluation: decides whether a branch opcode is taken from the latched flags.
module cpu_branch_cond
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 7
) (
  input  logic [OPC_W-1:0] opc_i,
  input  logic [3:0]       flags_i,
  output logic             taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (opc_i)
      OPC_W'(OpcBz):  taken_o = flags_i[FlagZ];
      OPC_W'(OpcBc):  taken_o = flags_i[FlagC];
      OPC_W'(OpcBs):  taken_o = flags_i[FlagS];
      OPC_W'(OpcBv):  taken_o = flags_i[FlagV];
      OPC_W'(OpcJmp): taken_o = 1'b1;
      default:        taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multicycle control FSM driving the CPU datapath: fetch, decode, R-type, LD, ST, branch, HALT.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 7,
  parameter int unsigned RA_W  = 3,
  parameter int unsigned ST_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [OPC_W-1:0] opc_i,
  input  logic [RA_W-1:0]  opd1_i,
  input  logic [RA_W-1:0]  opd2_i,
  input  logic [RA_W-1:0]  opd3_i,
  input  logic             C_i,
  input  logic             V_i,
  input  logic             S_i,
  input  logic             Z_det_i,
  output logic             ldPC_o,
  output logic             ldIR_o,
  output logic             ldMAR_o,
  output logic             ldtmp_o,
  output logic             ldMDRZ_o,
  output logic             ldMDRdata_o,
  output logic             ldALU_o,
  output logic             ldXPC_o,
  output logic             ldYPC_o,
  output logic             ldXtmp_o,
  output logic             ldYtmp_o,
  output logic             ldXreg_o,
  output logic             ldYreg_o,
  output logic             ldXmem_o,
  output logic             ldYmem_o,
  output logic             ldXtmp2_o,
  output logic             ldYtmp2_o,
  output logic             rd_mem_o,
  output logic             wr_mem_o,
  output logic             rd_reg_o,
  output logic             wr_reg_o,
  output logic [RA_W-1:0]  rd_regA_o,
  output logic [RA_W-1:0]  wr_regA_o,
  output logic [2:0]       fsel_o,
  output logic [ST_W-1:0]  state_o,
  output logic [ST_W-1:0]  next_state_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_e           state_q, state_d;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             taken;
  logic             is_rtype;

  assign is_rtype = (opc_i >= OPC_W'(OpcRFirst)) && (opc_i <= OPC_W'(OpcRLast));

  cpu_branch_cond #(
    .OPC_W(OPC_W)
  ) u_branch_cond (
    .opc_i  (opc_i),
    .flags_i(flags_q),
    .taken_o(taken)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StRst;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StR3) begin
        flags_q <= {C_i, V_i, S_i, Z_det_i};
      end
      // An instruction retires whenever the FSM returns to fetch, except right after reset.
      if ((state_d == StF0) && (state_q != StRst)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = StRst;
    unique case (state_q)
      StRst: state_d = StF0;
      StF0:  state_d = StF1;
      StF1:  state_d = StF2;
      StF2:  state_d = StF3;
      StF3:  state_d = StDec;
      StDec: begin
        if (is_rtype)                                        state_d = StR0;
        else if (opc_i == OPC_W'(OpcLd))                     state_d = StL0;
        else if (opc_i == OPC_W'(OpcSt))                     state_d = StS0;
        else if ((opc_i >= OPC_W'(OpcBz)) &&
                 (opc_i <= OPC_W'(OpcJmp)))                  state_d = StB0;
        else if (opc_i == OPC_W'(OpcHlt))                    state_d = StHlt;
        else                                                 state_d = StF0;
      end
      StR0:  state_d = StR1;
      StR1:  state_d = StR2;
      StR2:  state_d = StR3;
      StR3:  state_d = StF0;
      StL0:  state_d = StL1;
      StL1:  state_d = StL2;
      StL2:  state_d = StL3;
      StL3:  state_d = StF0;
      StS0:  state_d = StS1;
      StS1:  state_d = StS2;
      StS2:  state_d = StS3;
      StS3:  state_d = StS4;
      StS4:  state_d = StF0;
      StB0:  state_d = taken ? StB1 : StF0;
      StB1:  state_d = StB2;
      StB2:  state_d = StF0;
      StHlt: state_d = StHlt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    ldPC_o      = 1'b0;
    ldIR_o      = 1'b0;
    ldMAR_o     = 1'b0;
    ldtmp_o     = 1'b0;
    ldMDRZ_o    = 1'b0;
    ldMDRdata_o = 1'b0;
    ldALU_o     = 1'b0;
    ldXPC_o     = 1'b0;
    ldYtmp_o    = 1'b0;
    ldXreg_o    = 1'b0;
    ldYreg_o    = 1'b0;
    ldYtmp2_o   = 1'b0;
    rd_mem_o    = 1'b0;
    wr_mem_o    = 1'b0;
    rd_reg_o    = 1'b0;
    wr_reg_o    = 1'b0;
    rd_regA_o   = '0;
    wr_regA_o   = '0;
    fsel_o      = FselAdd;
    halted_o    = 1'b0;
    unique case (state_q)
      StF0: begin ldMAR_o = 1'b1; ldXPC_o = 1'b1; end
      StF1: begin rd_mem_o = 1'b1; ldMDRdata_o = 1'b1; end
      StF2: begin ldIR_o = 1'b1; ldYtmp_o = 1'b1; fsel_o = FselAdd; ldALU_o = 1'b1; end
      StF3: ldPC_o = 1'b1;
      StR0: begin rd_reg_o = 1'b1; rd_regA_o = opd2_i; ldXreg_o = 1'b1; end
      StR1: begin rd_reg_o = 1'b1; rd_regA_o = opd3_i; ldYreg_o = 1'b1; end
      // R-type opcodes 01..06 map onto ALU functions ADD..NOT.
      StR2: begin fsel_o = opc_i[2:0] - 3'd1; ldALU_o = 1'b1; end
      StR3: begin wr_reg_o = 1'b1; wr_regA_o = opd1_i; end
      StL0: begin rd_reg_o = 1'b1; rd_regA_o = opd2_i; ldtmp_o = 1'b1; end
      StL1: ldMAR_o = 1'b1;
      StL2: begin rd_mem_o = 1'b1; ldMDRdata_o = 1'b1; end
      StL3: begin wr_reg_o = 1'b1; wr_regA_o = opd1_i; end
      StS0: begin rd_reg_o = 1'b1; rd_regA_o = opd2_i; ldtmp_o = 1'b1; end
      StS1: begin ldMAR_o = 1'b1; rd_reg_o = 1'b1; rd_regA_o = opd1_i; ldXreg_o = 1'b1; end
      StS2: begin fsel_o = FselPassX; ldALU_o = 1'b1; end
      StS3: ldMDRZ_o = 1'b1;
      StS4: wr_mem_o = 1'b1;
      StB1: begin ldXPC_o = 1'b1; ldYtmp2_o = 1'b1; fsel_o = FselAdd; ldALU_o = 1'b1; end
      StB2: ldPC_o = 1'b1;
      StHlt: halted_o = 1'b1;
      default: ;
    endcase
  end

  assign ldYPC_o      = 1'b0;
  assign ldXtmp_o     = 1'b0;
  assign ldXmem_o     = 1'b0;
  assign ldYmem_o     = 1'b0;
  assign ldXtmp2_o    = 1'b0;
  assign state_o      = ST_W'(state_q);
  assign next_state_o = ST_W'(state_d);
  assign instr_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized self-checking bench for cpu_control_unit against an instruction-level model.
module tb_cpu_control_unit;

  localparam int unsigned CntW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] opc;
  logic [2:0] opd1, opd2, opd3;
  logic c_f, v_f, s_f, z_f;

  logic ld_pc, ld_ir, ld_mar, ld_tmp, ld_mdrz, ld_mdrdata, ld_alu, ld_xpc, ld_ypc, ld_xtmp;
  logic ld_ytmp, ld_xreg, ld_yreg, ld_xmem, ld_ymem, ld_xtmp2, ld_ytmp2;
  logic rd_mem, wr_mem, rd_reg, wr_reg, halted;
  logic [2:0] rd_ra, wr_ra, fsel;
  logic [4:0] state, next_state;
  logic [CntW-1:0] instr_cnt;

  always #5 clk = ~clk;

  cpu_control_unit #(
    .CNT_W(CntW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .opc_i       (opc),
    .opd1_i      (opd1),
    .opd2_i      (opd2),
    .opd3_i      (opd3),
    .C_i         (c_f),
    .V_i         (v_f),
    .S_i         (s_f),
    .Z_det_i     (z_f),
    .ldPC_o      (ld_pc),
    .ldIR_o      (ld_ir),
    .ldMAR_o     (ld_mar),
    .ldtmp_o     (ld_tmp),
    .ldMDRZ_o    (ld_mdrz),
    .ldMDRdata_o (ld_mdrdata),
    .ldALU_o     (ld_alu),
    .ldXPC_o     (ld_xpc),
    .ldYPC_o     (ld_ypc),
    .ldXtmp_o    (ld_xtmp),
    .ldYtmp_o    (ld_ytmp),
    .ldXreg_o    (ld_xreg),
    .ldYreg_o    (ld_yreg),
    .ldXmem_o    (ld_xmem),
    .ldYmem_o    (ld_ymem),
    .ldXtmp2_o   (ld_xtmp2),
    .ldYtmp2_o   (ld_ytmp2),
    .rd_mem_o    (rd_mem),
    .wr_mem_o    (wr_mem),
    .rd_reg_o    (rd_reg),
    .wr_reg_o    (wr_reg),
    .rd_regA_o   (rd_ra),
    .wr_regA_o   (wr_ra),
    .fsel_o      (fsel),
    .state_o     (state),
    .next_state_o(next_state),
    .halted_o    (halted),
    .instr_cnt_o (instr_cnt)
  );

  typedef struct packed {
    logic [4:0] state;
    logic [4:0] nxt;
    logic ld_pc, ld_ir, ld_mar, ld_tmp, ld_mdrz, ld_mdrdata, ld_alu;
    logic ld_xpc, ld_ytmp, ld_xreg, ld_yreg, ld_ytmp2;
    logic [4:0] zeros;
    logic rd_mem, wr_mem, rd_reg, wr_reg;
    logic [2:0] rd_a, wr_a, fsel;
    logic halted;
    logic [CntW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t trace[$];
  int vectors = 0;
  int miscompares = 0;
  int m_cnt = 0;
  logic [3:0] m_flags = 4'b0000;  // {C, V, S, Z}

  function automatic obs_t sample();
    obs_t a;
    a = '0;
    a.state = state; a.nxt = next_state;
    a.ld_pc = ld_pc; a.ld_ir = ld_ir; a.ld_mar = ld_mar; a.ld_tmp = ld_tmp;
    a.ld_mdrz = ld_mdrz; a.ld_mdrdata = ld_mdrdata; a.ld_alu = ld_alu;
    a.ld_xpc = ld_xpc; a.ld_ytmp = ld_ytmp; a.ld_xreg = ld_xreg; a.ld_yreg = ld_yreg;
    a.ld_ytmp2 = ld_ytmp2;
    a.zeros = {ld_ypc, ld_xtmp, ld_xmem, ld_ymem, ld_xtmp2};
    a.rd_mem = rd_mem; a.wr_mem = wr_mem; a.rd_reg = rd_reg; a.wr_reg = wr_reg;
    a.rd_a = rd_ra; a.wr_a = wr_ra; a.fsel = fsel; a.halted = halted; a.cnt = instr_cnt;
    return a;
  endfunction

  // One-cycle output profile of a state, straight from the state table.
  function automatic obs_t expect_out(int st, logic [6:0] op, logic [2:0] a, logic [2:0] b,
                                      logic [2:0] cc);
    obs_t e;
    e = '0;
    e.state = 5'(st);
    case (st)
      1:  begin e.ld_mar = 1; e.ld_xpc = 1; end
      2:  begin e.rd_mem = 1; e.ld_mdrdata = 1; end
      3:  begin e.ld_ir = 1; e.ld_ytmp = 1; e.ld_alu = 1; end
      4:  e.ld_pc = 1;
      6:  begin e.rd_reg = 1; e.rd_a = b; e.ld_xreg = 1; end
      7:  begin e.rd_reg = 1; e.rd_a = cc; e.ld_yreg = 1; end
      8:  begin e.fsel = 3'(op - 7'd1); e.ld_alu = 1; end
      9:  begin e.wr_reg = 1; e.wr_a = a; end
      10: begin e.rd_reg = 1; e.rd_a = b; e.ld_tmp = 1; end
      11: e.ld_mar = 1;
      12: begin e.rd_mem = 1; e.ld_mdrdata = 1; end
      13: begin e.wr_reg = 1; e.wr_a = a; end
      14: begin e.rd_reg = 1; e.rd_a = b; e.ld_tmp = 1; end
      15: begin e.ld_mar = 1; e.rd_reg = 1; e.rd_a = a; e.ld_xreg = 1; end
      16: begin e.fsel = 3'd7; e.ld_alu = 1; end
      17: e.ld_mdrz = 1;
      18: e.wr_mem = 1;
      20: begin e.ld_xpc = 1; e.ld_ytmp2 = 1; e.ld_alu = 1; end
      21: e.ld_pc = 1;
      22: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  // 1 R-type, 2 LD, 3 ST, 4 branch, 5 halt, 0 anything else (NOP).
  function automatic int classify(logic [6:0] op);
    if (op >= 7'h01 && op <= 7'h06) return 1;
    if (op == 7'h10) return 2;
    if (op == 7'h11) return 3;
    if (op >= 7'h20 && op <= 7'h24) return 4;
    if (op == 7'h7F) return 5;
    return 0;
  endfunction

  function automatic bit br_taken(logic [6:0] op, logic [3:0] fl);
    case (op)
      7'h20: return fl[0];
      7'h21: return fl[3];
      7'h22: return fl[1];
      7'h23: return fl[2];
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    obs_t act;
    obs_t e;
    act = sample();
    trace.push_back(act);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL cycle_check @%0t st=%0d: got %h required %h", $time, e.state, act, e);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_trace(input string name, input int req[$]);
    bit bad;
    bad = (trace.size() != req.size());
    for (int i = 0; i < req.size() && !bad; i++) begin
      if (int'(trace[i].state) != req[i]) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got %0d states (first %0d), required %0d states (first %0d)", name,
               trace.size(), (trace.size() > 0) ? int'(trace[0].state) : -1, req.size(), req[0]);
    end
  endtask

  // Called at posedge+2 with the DUT in F0: queue the whole instruction and drive its fields.
  task automatic push_instr(input logic [6:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] cc, input logic [3:0] fl, input int hlt_cycles,
                            output int n);
    int st[$];
    int cls;
    obs_t e;
    for (int i = 1; i <= 5; i++) st.push_back(i);
    cls = classify(op);
    case (cls)
      1: for (int i = 6; i <= 9; i++) st.push_back(i);
      2: for (int i = 10; i <= 13; i++) st.push_back(i);
      3: for (int i = 14; i <= 18; i++) st.push_back(i);
      4: begin
        st.push_back(19);
        if (br_taken(op, m_flags)) begin st.push_back(20); st.push_back(21); end
      end
      5: for (int i = 0; i < hlt_cycles; i++) st.push_back(22);
      default: ;
    endcase
    for (int i = 0; i < st.size(); i++) begin
      e = expect_out(st[i], op, a, b, cc);
      e.cnt = CntW'(m_cnt);
      e.nxt = (i + 1 < st.size()) ? 5'(st[i+1]) : ((cls == 5) ? 5'd22 : 5'd1);
      exp_q.push_back(e);
    end
    n = st.size();
    if (cls == 1) m_flags = fl;
    if (cls != 5) m_cnt = (m_cnt + 1) % (1 << CntW);
    opc = op; opd1 = a; opd2 = b; opd3 = cc;
    {c_f, v_f, s_f, z_f} = fl;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] cc, input logic [3:0] fl);
    int n;
    push_instr(op, a, b, cc, fl, 0, n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    obs_t e;
    reset = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    m_flags = 4'b0000;
    #1;
    check_lit("rst_state", int'(state), 0);
    check_lit("rst_rd_mem", int'(rd_mem), 0);
    check_lit("rst_cnt", int'(instr_cnt), 0);
    e = expect_out(0, 7'h00, 3'd0, 3'd0, 3'd0);
    e.nxt = 5'd1;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [6:0] rand_opc();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0, 1, 2: op = 7'($urandom_range(1, 6));
      3:       op = 7'h10;
      4:       op = 7'h11;
      5, 6:    op = 7'($urandom_range(32, 36));
      7: begin
        op = 7'($urandom_range(0, 127));
        while (classify(op) != 0) op = 7'($urandom_range(0, 127));
      end
      default: begin
        case ($urandom_range(0, 6))
          0: op = 7'h00; 1: op = 7'h07; 2: op = 7'h0F; 3: op = 7'h12;
          4: op = 7'h1F; 5: op = 7'h25; default: op = 7'h7E;
        endcase
      end
    endcase
    return op;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt_h;
    int cnt_w;
    reset = 1'b1;
    opc = '0; opd1 = '0; opd2 = '0; opd3 = '0;
    {c_f, v_f, s_f, z_f} = 4'b0000;
    @(posedge clk);
    #2;
    do_reset();
    check_lit("after_reset_state", int'(state), 1);
    check_lit("after_reset_ldmar", int'(ld_mar), 1);

    // ADD r3 <- r1, r2
    trace.delete();
    run_instr(7'h01, 3'd3, 3'd1, 3'd2, 4'b0000);
    check_trace("add_seq", '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    check_lit("add_ra_r0", int'(trace[5].rd_a), 1);
    check_lit("add_ra_r1", int'(trace[6].rd_a), 2);
    check_lit("add_fsel", int'(trace[7].fsel), 0);
    check_lit("add_wa", int'(trace[8].wr_a), 3);
    check_lit("add_cnt", int'(instr_cnt), 1);
    check_lit("add_back_f0", int'(state), 1);

    // SUB sets Z, then BZ taken; SUB clears Z, then BZ not taken
    run_instr(7'h02, 3'd1, 3'd2, 3'd3, 4'b0001);
    trace.delete();
    run_instr(7'h20, 3'd0, 3'd0, 3'd0, 4'b0000);
    check_trace("bz_taken", '{1, 2, 3, 4, 5, 19, 20, 21});
    run_instr(7'h02, 3'd1, 3'd2, 3'd3, 4'b1110);
    trace.delete();
    run_instr(7'h20, 3'd0, 3'd0, 3'd0, 4'b0001);
    check_trace("bz_not_taken", '{1, 2, 3, 4, 5, 19});

    // ST mem[r5] <- r4
    trace.delete();
    run_instr(7'h11, 3'd4, 3'd5, 3'd0, 4'b0000);
    check_trace("st_seq", '{1, 2, 3, 4, 5, 14, 15, 16, 17, 18});
    check_lit("st_ra_s0", int'(trace[5].rd_a), 5);
    check_lit("st_ra_s1", int'(trace[6].rd_a), 4);
    check_lit("st_fsel", int'(trace[7].fsel), 7);
    cnt_w = 0;
    foreach (trace[i]) cnt_w += int'(trace[i].wr_mem);
    check_lit("st_wr_mem_pulses", cnt_w, 1);

    // Unknown opcode retires as NOP, then HALT for 100 cycles
    do_reset();
    trace.delete();
    run_instr(7'h3A, 3'd0, 3'd0, 3'd0, 4'b0000);
    check_trace("nop_seq", '{1, 2, 3, 4, 5});
    check_lit("nop_cnt", int'(instr_cnt), 1);
    trace.delete();
    push_instr(7'h7F, 3'd0, 3'd0, 3'd0, 4'b1111, 100, n);
    repeat (n) @(posedge clk);
    #2;
    cnt_h = 0;
    foreach (trace[i]) cnt_h += int'(trace[i].halted);
    check_lit("halt_cycles", cnt_h, 100);
    check_lit("halt_cnt", int'(instr_cnt), 1);
    check_lit("halt_state", int'(state), 22);
    do_reset();

    // Counter wrap
    for (int i = 0; i < (1 << CntW) - 1; i++) run_instr(7'h00, 3'd0, 3'd0, 3'd0, 4'b0000);
    check_lit("cnt_max", int'(instr_cnt), (1 << CntW) - 1);
    run_instr(7'h00, 3'd0, 3'd0, 3'd0, 4'b0000);
    check_lit("cnt_wrap", int'(instr_cnt), 0);

    // Reset while in L2 abandons the load
    push_instr(7'h10, 3'd2, 3'd3, 3'd0, 4'b0000, 0, n);
    repeat (7) @(posedge clk);
    #2;
    check_lit("ld_in_l2", int'(state), 12);
    do_reset();

    // Randomized instruction stream with occasional mid-instruction resets
    for (int k = 0; k < 300; k++) begin
      logic [6:0] op;
      logic [2:0] a, b, cc;
      logic [3:0] fl;
      op = rand_opc();
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      cc = 3'($urandom_range(0, 7));
      fl = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        push_instr(op, a, b, cc, fl, 0, n);
        repeat ($urandom_range(1, n - 1)) @(posedge clk);
        #2;
        do_reset();
      end else begin
        run_instr(op, a, b, cc, fl);
      end
    end
    repeat (2) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
